// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 boot/run controller and the benches around it.
//   boot_state_t : controller FSM states
//   ADDR_W_DEF / DATA_W_DEF : default RAM geometry (4K x 16)
//   mu0_op_t / mu0_word : MU0 opcodes and a word assembler for loader images
package mu0_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RESET,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } boot_state_t;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_STO = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_JMP = 4'h4,
    OP_JGE = 4'h5,
    OP_JNE = 4'h6,
    OP_STP = 4'h7
  } mu0_op_t;

  // Opcode in the top nibble, 12-bit operand address below it.
  function automatic logic [15:0] mu0_word(input mu0_op_t op, input logic [11:0] operand);
    return {op, operand};
  endfunction

endpackage

// File: rtl/mu0_cycle_counter.sv
// Saturating run-cycle counter.
//   clk, rst    : clock, async active-high reset
//   clr_i       : synchronous clear (wins over en_i)
//   en_i        : count this edge
//   count_o     : current count, sticks at all-ones
//   hit_o       : the next enabled edge brings the count to MAX_CYCLES
module mu0_cycle_counter #(
  parameter int COUNT_W    = 32,
  parameter int MAX_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               en_i,
  output logic [COUNT_W-1:0] count_o,
  output logic               hit_o
);

  // Budget must be representable in COUNT_W bits for hit_o to ever fire.
  localparam logic [COUNT_W-1:0] HIT_VAL = COUNT_W'(MAX_CYCLES - 1);

  logic [COUNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)                        count_d = '0;
    else if (en_i && count_q != '1)   count_d = count_q + COUNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;
  // Looks one edge ahead so the FSM leaves RUN on the edge the count lands on the budget.
  assign hit_o   = (count_q == HIT_VAL);

endmodule

// File: rtl/mu0_boot_ctrl.sv
// MU0 boot and run controller.
// Streams a program image into the RAM, holds the CPU in reset for RESET_CYCLES,
// then gives the RAM bus to the CPU and watches cpu_running until halt or budget.
//   start                               : begin a load session (IDLE/DONE/TIMEOUT only)
//   load_valid/ready/data/last          : image word stream
//   cpu_running/address/read/write/writedata : CPU side of the RAM bus
//   cpu_rst                             : CPU reset (also asserted by rst)
//   mem_*                               : RAM bus
//   busy/done/timeout/cycle_count       : status
module mu0_boot_ctrl
  import mu0_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 1024,
  parameter int COUNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [DATA_W-1:0]  load_data,
  input  logic               load_last,
  input  logic               cpu_running,
  input  logic [ADDR_W-1:0]  cpu_address,
  input  logic               cpu_read,
  input  logic               cpu_write,
  input  logic [DATA_W-1:0]  cpu_writedata,
  output logic               cpu_rst,
  output logic [ADDR_W-1:0]  mem_address,
  output logic               mem_read,
  output logic               mem_write,
  output logic [DATA_W-1:0]  mem_writedata,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [COUNT_W-1:0] cycle_count
);

  localparam int          RC_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);

  boot_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic              done_q, done_d;
  logic              tmo_q, tmo_d;
  logic              cnt_clr, cnt_en, cnt_hit;

  mu0_cycle_counter #(
    .COUNT_W   (COUNT_W),
    .MAX_CYCLES(MAX_CYCLES)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .count_o(cycle_count),
    .hit_o  (cnt_hit)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rcnt_d        = rcnt_q;
    done_d        = done_q;
    tmo_d         = tmo_q;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    load_ready    = 1'b0;
    mem_address   = '0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_writedata = '0;

    unique case (state_q)
      ST_IDLE: begin
        addr_d  = '0;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        cnt_clr = 1'b1;
        if (start) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        // ready is constant here, so valid alone marks the handshake and the write.
        load_ready    = 1'b1;
        mem_address   = addr_q;
        mem_writedata = load_data;
        mem_write     = load_valid;
        if (load_valid) begin
          // The top address ends the image even without last; no second pass.
          if (load_last || addr_q == '1) begin
            state_d = ST_RESET;
            rcnt_d  = '0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end

      ST_RESET: begin
        if (rcnt_q == RC_LAST) state_d = ST_RUN;
        else                   rcnt_d  = rcnt_q + RC_W'(1);
      end

      ST_RUN: begin
        mem_address   = cpu_address;
        mem_read      = cpu_read;
        mem_write     = cpu_write;
        mem_writedata = cpu_writedata;
        // A halt is checked first so it beats a budget hit on the same edge.
        if (!cpu_running) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_en = 1'b1;
          if (cnt_hit) begin
            state_d = ST_TIMEOUT;
            tmo_d   = 1'b1;
          end
        end
      end

      ST_DONE, ST_TIMEOUT: begin
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          done_d  = 1'b0;
          tmo_d   = 1'b0;
          cnt_clr = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rcnt_q  <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rcnt_q  <= rcnt_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  // rst is folded in so the CPU is reset together with the system, not a cycle later.
  assign cpu_rst = rst || (state_q == ST_RESET) || (state_q == ST_TIMEOUT);
  assign busy    = (state_q == ST_LOAD) || (state_q == ST_RESET) || (state_q == ST_RUN);
  assign done    = done_q;
  assign timeout = tmo_q;

endmodule

// File: tb/tb_mu0_boot_ctrl.sv
module tb_mu0_boot_ctrl;
  import mu0_pkg::*;

  localparam int AW = 12, DW = 16, RC = 2, MAXC = 16, CW = 32;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic load_valid = 1'b0, load_last = 1'b0, cpu_running = 1'b0;
  logic cpu_read = 1'b0, cpu_write = 1'b0;
  logic [DW-1:0] load_data = '0, cpu_writedata = '0;
  logic [AW-1:0] cpu_address = '0;
  logic          load_ready, cpu_rst, mem_read, mem_write, busy, done, timeout;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata;
  logic [CW-1:0] cycle_count;

  always #5 clk = ~clk;

  mu0_boot_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .RESET_CYCLES(RC), .MAX_CYCLES(MAXC), .COUNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .cpu_running(cpu_running), .cpu_address(cpu_address), .cpu_read(cpu_read),
    .cpu_write(cpu_write), .cpu_writedata(cpu_writedata), .cpu_rst(cpu_rst),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .busy(busy), .done(done), .timeout(timeout),
    .cycle_count(cycle_count)
  );

  int errors = 0, checks = 0;

  // Every RAM write the DUT commits, in order.
  logic [AW+DW-1:0] wlog[$];
  always @(posedge clk) if (mem_write) wlog.push_back({mem_address, mem_writedata});

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic st, vl, lst, run, crd, cwr;
    logic [15:0] dat;
    logic rdy, mw, mr, crst, bsy, dn;
    logic [11:0] ma;
    logic [15:0] md;
    logic [7:0]  cnt;
  } vec_t;

  function automatic vec_t v(input logic st, vl, lst, run, crd, cwr, input logic [15:0] dat,
                             input logic rdy, mw, mr, crst, bsy, dn,
                             input logic [11:0] ma, input logic [15:0] md, input logic [7:0] cnt);
    vec_t r;
    r.st = st; r.vl = vl; r.lst = lst; r.run = run; r.crd = crd; r.cwr = cwr; r.dat = dat;
    r.rdy = rdy; r.mw = mw; r.mr = mr; r.crst = crst; r.bsy = bsy; r.dn = dn;
    r.ma = ma; r.md = md; r.cnt = cnt;
    return r;
  endfunction

  // One full session: reset pulse, start, load n words with random gaps, then the
  // CPU reports running for r edges. Expected outcome comes from the budget rule.
  task automatic session(input string tag, input int n, input int r, input int gap_pct,
                         input logic [63:0] fixed);
    logic [15:0] words[$];
    int k, cyc, rc;
    logic exp_to;
    @(negedge clk);
    rst = 1'b1; start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    cpu_running = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
    #2 rst = 1'b0;
    wlog.delete();
    for (int i = 0; i < n; i++)
      words.push_back(i < 4 ? fixed[63-16*i -: 16] : 16'($urandom));
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0; cyc = 0;
    while (k < n && cyc < 200) begin
      load_valid = ($urandom_range(99) >= gap_pct);
      load_data  = words[k];
      load_last  = (k == n - 1);
      #1 chk({tag, "_ready"}, load_ready, 1);
      if (load_valid) k++;
      @(negedge clk); cyc++;
    end
    chk({tag, "_load_bound"}, k, n);
    load_valid = 1'b0; load_last = 1'b0; rc = 0;
    for (int t = 0; t < 20; t++) begin
      cpu_running = 1'b1; cpu_write = 1'b0; cpu_read = 1'($urandom);
      cpu_address = AW'($urandom); cpu_writedata = DW'($urandom);
      #1;
      if (!cpu_rst) break;
      rc++;
      @(negedge clk);
    end
    chk({tag, "_rst_cycles"}, rc, RC);
    chk({tag, "_pass"}, {mem_address, mem_writedata, mem_read, mem_write},
        {cpu_address, cpu_writedata, cpu_read, 1'b0});
    for (int t = 1; t < r; t++) begin @(negedge clk); cpu_running = 1'b1; end
    @(negedge clk); cpu_running = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    exp_to = (r >= MAXC);
    chk({tag, "_done"}, done, !exp_to);
    chk({tag, "_timeout"}, timeout, exp_to);
    chk({tag, "_count"}, cycle_count, exp_to ? MAXC : r);
    chk({tag, "_cpu_rst"}, cpu_rst, exp_to);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_nwrites"}, wlog.size(), n);
    for (int i = 0; i < n; i++)
      if (i < wlog.size()) chk($sformatf("%s_wr%0d", tag, i), wlog[i], {AW'(i), words[i]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    tbl[0]  = v(0,0,0,0,0,0,16'h0000, 0,0,0,0,0,0, 12'h0,16'h0000,8'd0);
    tbl[1]  = v(1,0,0,0,0,0,16'h0000, 0,0,0,0,0,0, 12'h0,16'h0000,8'd0);
    tbl[2]  = v(0,1,0,0,0,0,16'hA111, 1,1,0,0,1,0, 12'h0,16'hA111,8'd0);
    tbl[3]  = v(0,0,0,0,0,0,16'h2222, 1,0,0,0,1,0, 12'h1,16'h2222,8'd0);
    tbl[4]  = v(0,0,0,0,0,0,16'h2222, 1,0,0,0,1,0, 12'h1,16'h2222,8'd0);
    tbl[5]  = v(0,1,0,0,0,0,16'hB222, 1,1,0,0,1,0, 12'h1,16'hB222,8'd0);
    tbl[6]  = v(0,1,1,0,0,0,16'hC333, 1,1,0,0,1,0, 12'h2,16'hC333,8'd0);
    tbl[7]  = v(0,1,0,1,0,0,16'hD444, 0,0,0,1,1,0, 12'h0,16'h0000,8'd0);
    tbl[8]  = v(0,0,0,1,0,0,16'h0000, 0,0,0,1,1,0, 12'h0,16'h0000,8'd0);
    tbl[9]  = v(1,0,0,1,0,1,16'h0000, 0,1,0,0,1,0, 12'h5,16'hBEEF,8'd0);
    tbl[10] = v(1,0,0,1,1,0,16'h0000, 0,0,1,0,1,0, 12'h5,16'hBEEF,8'd1);
    tbl[11] = v(0,0,0,0,0,0,16'h0000, 0,0,0,0,1,0, 12'h5,16'hBEEF,8'd2);
    tbl[12] = v(1,0,0,0,0,0,16'h0000, 0,0,0,0,0,1, 12'h0,16'h0000,8'd2);
    tbl[13] = v(0,0,0,0,0,0,16'h0000, 1,0,0,0,1,0, 12'h0,16'h0000,8'd0);

    // Reset state, sampled while rst is still high.
    #3;
    chk("rst_outputs", {load_ready, mem_read, mem_write, mem_address, mem_writedata, busy, done, timeout},
        '0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_count", cycle_count, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    wlog.delete();

    // Valid gaps, RESET length, RUN passthrough, start ignored in RUN, start from DONE.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      start = tbl[i].st; load_valid = tbl[i].vl; load_last = tbl[i].lst; load_data = tbl[i].dat;
      cpu_running = tbl[i].run; cpu_read = tbl[i].crd; cpu_write = tbl[i].cwr;
      cpu_address = 12'h005; cpu_writedata = 16'hBEEF;
      #1;
      chk($sformatf("vec%0d", i),
          {load_ready, mem_write, mem_read, cpu_rst, busy, done, timeout, mem_address, mem_writedata,
           cycle_count[7:0]},
          {tbl[i].rdy, tbl[i].mw, tbl[i].mr, tbl[i].crst, tbl[i].bsy, tbl[i].dn, 1'b0, tbl[i].ma,
           tbl[i].md, tbl[i].cnt});
    end
    chk("vec_nwrites", wlog.size(), 4);
    if (wlog.size() == 4) begin
      chk("vec_wr0", wlog[0], {12'h000, 16'hA111});
      chk("vec_wr1", wlog[1], {12'h001, 16'hB222});
      chk("vec_wr2", wlog[2], {12'h002, 16'hC333});
      chk("vec_wr3", wlog[3], {12'h005, 16'hBEEF});
    end

    // Async reset mid-load (DUT is in LOAD at address 0).
    wlog.delete();
    start = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_running = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); load_valid = 1'b1; load_last = 1'b0; load_data = 16'(16'h1000 + k);
    end
    @(negedge clk); load_data = 16'h1002;
    #1 chk("arst_pre_write", mem_write, 1);
    #1 rst = 1'b1;
    #1 chk("arst_during", {mem_write, load_ready, cpu_rst, busy}, 4'b0010);
    #1 rst = 1'b0; load_valid = 1'b0;
    @(negedge clk);
    chk("arst_nwrites", wlog.size(), 2);
    if (wlog.size() == 2) chk("arst_wr1", wlog[1], {12'h001, 16'h1001});
    start = 1'b1;
    @(negedge clk); start = 1'b0; load_valid = 1'b1; load_data = 16'h2000;
    #1 chk("arst_reload_addr", {mem_write, mem_address}, {1'b1, 12'h000});
    load_valid = 1'b0;

    // Hand-written sessions: normal halt, budget boundaries, timeout.
    session("normal", 4, 6, 0, 64'h0003_8000_7000_0005);
    session("under", 3, MAXC - 1, 30, 64'h0);
    session("exact", 2, MAXC, 0, 64'h0);
    session("timeout", 1, 40, 0, {mu0_word(OP_JMP, 12'h000), 48'h0});

    // Wrap guard: a full 4K image without last.
    @(negedge clk);
    rst = 1'b1; start = 1'b0; load_valid = 1'b0; cpu_running = 1'b0; cpu_write = 1'b0;
    #2 rst = 1'b0;
    wlog.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      load_valid = 1'b1; load_last = 1'b0; load_data = 16'(i);
      @(negedge clk);
    end
    #1 chk("wrap_ready_low", {load_ready, cpu_rst}, 2'b01);
    repeat (3) @(negedge clk);
    load_valid = 1'b0;
    chk("wrap_nwrites", wlog.size(), 4096);
    if (wlog.size() >= 4096) begin
      chk("wrap_first", wlog[0], {12'h000, 16'h0000});
      chk("wrap_last", wlog[4095], {12'hFFF, 16'h0FFF});
    end

    // Randomized sessions.
    for (int it = 0; it < 10; it++)
      session($sformatf("rnd%0d", it), $urandom_range(1, 12), $urandom_range(1, 24),
              $urandom_range(0, 50), {$urandom, $urandom});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
